// File: rtl/axi4_slave_read_data_channel.sv
// rtl/axi4_slave_read_data_channel.sv - AXI4 slave read-data responder (R channel)
//
// Purpose: takes the burst descriptor presented at the AR handshake. It walks
// the FIXED/INCR/WRAP address sequence, issues one synchronous memory read per
// beat, and returns RDATA/RID/RRESP/RLAST under RREADY backpressure.
//
// Optional macro: AXI_RD_PIPELINE_EN
//   defined   - the read for the next beat is issued in the same cycle as the
//               current beat's handshake, giving one beat per cycle.
//   undefined - every beat passes through R_FETCH, giving one beat per two
//               cycles. mem_rd_en never depends on rready.
//
// Ports:
//   clk, rst                 clock (rising edge) and async active-low reset
//   arvalid, arready         observed AR handshake
//   stored_ar*               burst descriptor, valid in the AR handshake cycle
//   busy                     high while a burst is in progress
//   mem_rd_en, mem_addr      synchronous memory read request
//   mem_rd_data              memory data, valid the cycle after mem_rd_en
//   rvalid, rready, rdata,
//   rid, rresp, rlast        AXI4 R channel
//   r_transfer_done          one-cycle pulse on the final beat handshake
module axi4_slave_read_data_channel #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arvalid,
    input  logic                  arready,
    input  logic [ADDR_WIDTH-1:0] stored_araddr,
    input  logic [ID_WIDTH-1:0]   stored_arid,
    input  logic [7:0]            stored_arlen,
    input  logic [2:0]            stored_arsize,
    input  logic [1:0]            stored_arburst,
    output logic                  busy,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  r_transfer_done
);

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_FETCH = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    logic [1:0]            state_q,     state_d;
    logic [8:0]            beats_q,     beats_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [ADDR_WIDTH-1:0] wrap_base_q, wrap_base_d;
    logic [ADDR_WIDTH-1:0] container_q, container_d;
    logic [ID_WIDTH-1:0]   id_q,        id_d;
    logic [2:0]            size_q,      size_d;
    logic [1:0]            burst_q,     burst_d;

    logic                  ar_hs;
    logic                  rd_hs;
    logic                  last_beat;
    logic                  pipe_fetch;
    logic [ADDR_WIDTH-1:0] num_bytes;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] ar_container;

    assign ar_hs     = arvalid && arready;
    assign rd_hs     = (state_q == R_DATA) && rready;
    assign last_beat = (beats_q == 9'd1);

    // The wrap window is (len+1) << size bytes. Its base is the start address
    // aligned down to that window; both are fixed for the life of the burst.
    assign ar_container = ADDR_WIDTH'({1'b0, stored_arlen} + 9'd1) << stored_arsize;

    assign num_bytes = ADDR_WIDTH'(1) << size_q;
    assign incr_addr = addr_q + num_bytes;

    // Reserved bursts fall through to the INCR step.
    // Equality (not >=) keeps the wrap test correct when the window ends at
    // the top of the address space and the sum rolls over to zero.
    always_comb begin
        next_addr = incr_addr;
        if (burst_q == BURST_FIXED) begin
            next_addr = addr_q;
        end else if (burst_q == BURST_WRAP && incr_addr == (wrap_base_q + container_q)) begin
            next_addr = wrap_base_q;
        end
    end

`ifdef AXI_RD_PIPELINE_EN
    // Prefetch the next beat while the current one is being accepted.
    assign pipe_fetch = rd_hs && !last_beat;
`else
    assign pipe_fetch = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        beats_d     = beats_q;
        addr_d      = addr_q;
        wrap_base_d = wrap_base_q;
        container_d = container_q;
        id_d        = id_q;
        size_d      = size_q;
        burst_d     = burst_q;
        case (state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    id_d        = stored_arid;
                    beats_d     = {1'b0, stored_arlen} + 9'd1;
                    size_d      = stored_arsize;
                    burst_d     = stored_arburst;
                    addr_d      = stored_araddr;
                    container_d = ar_container;
                    wrap_base_d = stored_araddr & ~(ar_container - ADDR_WIDTH'(1));
                    state_d     = R_FETCH;
                end
            end
            R_FETCH: begin
                state_d = R_DATA;
            end
            R_DATA: begin
                if (rd_hs) begin
                    if (last_beat) begin
                        state_d = R_IDLE;
                    end else begin
                        beats_d = beats_q - 9'd1;
                        addr_d  = next_addr;
`ifdef AXI_RD_PIPELINE_EN
                        state_d = R_DATA;
`else
                        state_d = R_FETCH;
`endif
                    end
                end
            end
            default: begin
                state_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= R_IDLE;
            beats_q     <= '0;
            addr_q      <= '0;
            wrap_base_q <= '0;
            container_q <= '0;
            id_q        <= '0;
            size_q      <= '0;
            burst_q     <= '0;
        end else begin
            state_q     <= state_d;
            beats_q     <= beats_d;
            addr_q      <= addr_d;
            wrap_base_q <= wrap_base_d;
            container_q <= container_d;
            id_q        <= id_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
        end
    end

    assign busy            = (state_q != R_IDLE);
    assign rvalid          = (state_q == R_DATA);
    assign mem_rd_en       = (state_q == R_FETCH) || pipe_fetch;
    assign mem_addr        = pipe_fetch ? next_addr : addr_q;
    assign rdata           = rvalid ? mem_rd_data : '0;
    assign rid             = id_q;
    assign rresp           = (rvalid && burst_q == BURST_RSVD) ? 2'b10 : 2'b00;
    assign rlast           = rvalid && last_beat;
    assign r_transfer_done = rd_hs && last_beat;

endmodule

// File: tb/tb_axi4_slave_read_data_channel.sv
// tb/tb_axi4_slave_read_data_channel.sv - scoreboard bench for axi4_slave_read_data_channel
module tb_axi4_slave_read_data_channel;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 4;
`ifdef AXI_RD_PIPELINE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          arvalid = 1'b0;
    logic          arready = 1'b0;
    logic [AW-1:0] stored_araddr = '0;
    logic [IW-1:0] stored_arid = '0;
    logic [7:0]    stored_arlen = '0;
    logic [2:0]    stored_arsize = '0;
    logic [1:0]    stored_arburst = '0;
    logic          busy;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          rvalid;
    logic          rready = 1'b1;
    logic [DW-1:0] rdata;
    logic [IW-1:0] rid;
    logic [1:0]    rresp;
    logic          rlast;
    logic          r_transfer_done;

    axi4_slave_read_data_channel #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .arvalid(arvalid), .arready(arready),
        .stored_araddr(stored_araddr), .stored_arid(stored_arid),
        .stored_arlen(stored_arlen), .stored_arsize(stored_arsize),
        .stored_arburst(stored_arburst),
        .busy(busy), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid),
        .rresp(rresp), .rlast(rlast), .r_transfer_done(r_transfer_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic [1:0]    resp;
        logic          last;
        int            cyc;
    } beat_t;

    beat_t         sb[$];
    logic [AW-1:0] aq[$];
    int errors = 0;
    int checks = 0;
    int rr_mode = 0;

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
    endfunction

    // Synchronous-read memory: data appears the cycle after the strobe and holds.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_fn(mem_addr);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // rready driver: 0 = always high, 1 = random, 2 = left to the stimulus.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_mode == 0) rready = 1'b1;
            else if (rr_mode == 1) rready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops expected reads and beats as the DUT presents them.
    logic          held_v = 1'b0;
    logic [DW-1:0] held_data;
    logic [IW-1:0] held_id;
    logic          held_last;
    always @(negedge clk) begin : mon
        beat_t e;
        if (!rst) begin
            held_v = 1'b0;
        end else begin
            if (mem_rd_en) begin
                if (aq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: addr %0h with no read expected", mem_addr);
                end else begin
                    chk("mem_addr", mem_addr, aq.pop_front());
                end
            end
            if (held_v) begin
                chk("stall_rvalid", rvalid, 1);
                chk("stall_rdata", rdata, held_data);
                chk("stall_rid", rid, held_id);
                chk("stall_rlast", rlast, held_last);
            end
            if (!rvalid) chk("idle_rdata_zero", rdata, 0);
            if (rvalid && rready) begin
                held_v = 1'b0;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: rdata %0h with no beat expected", rdata);
                end else begin
                    e = sb.pop_front();
                    chk("rdata", rdata, e.data);
                    chk("rid", rid, e.id);
                    chk("rresp", rresp, e.resp);
                    chk("rlast", rlast, e.last);
                    chk("r_transfer_done", r_transfer_done, e.last);
                    if (e.cyc >= 0) chk("beat_cycle", cyc, e.cyc);
                end
            end else begin
                if (r_transfer_done) begin
                    checks++; errors++;
                    $display("FAIL spurious_done: r_transfer_done 1 expected 0");
                end
                if (rvalid) begin
                    held_v    = 1'b1;
                    held_data = rdata;
                    held_id   = rid;
                    held_last = rlast;
                    chk("stall_no_rd_en", mem_rd_en, 0);
                end else begin
                    held_v = 1'b0;
                end
            end
        end
    end

    // Issues one AR handshake and pushes the reference read addresses and beats.
    task automatic issue(input logic [AW-1:0] addr, input logic [IW-1:0] id,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input bit timed);
        int n = 0;
        int t;
        longint nb, cont, lower, a;
        @(posedge clk); #1;
        while (busy && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL busy_timeout: busy 1 expected 0");
            return;
        end
        arvalid = 1'b1; arready = 1'b1;
        stored_araddr = addr; stored_arid = id; stored_arlen = len;
        stored_arsize = size; stored_arburst = burst;
        t = cyc;
        nb    = longint'(1) << size;
        cont  = nb * (longint'(len) + 1);
        lower = (longint'(addr) / cont) * cont;
        for (int k = 0; k <= int'(len); k++) begin
            if (burst == 2'b10) a = lower + ((longint'(addr) - lower) + k * nb) % cont;
            else if (burst == 2'b00) a = longint'(addr);
            else a = longint'(addr) + k * nb;
            aq.push_back(a[AW-1:0]);
            sb.push_back('{mem_fn(a[AW-1:0]), id, (burst == 2'b11) ? 2'b10 : 2'b00,
                           (k == int'(len)), timed ? (t + 2 + (PIPE ? k : 2 * k)) : -1});
        end
        @(posedge clk); #1;
        arvalid = 1'b0; arready = 1'b0;
        stored_araddr = $urandom; stored_arid = IW'($urandom);
        stored_arlen = 8'($urandom); stored_arsize = 3'($urandom);
        stored_arburst = 2'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || aq.size() != 0 || busy) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0 || aq.size() != 0 || busy) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d beats %0d reads outstanding", sb.size(), aq.size());
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {busy, mem_rd_en, rvalid, rlast, r_transfer_done, rid, rresp}, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        rr_mode = 0;
        issue(32'h100, 4'h3, 8'd3, 3'd2, 2'b01, 1'b1);
        wait_idle();
        issue(32'h108, 4'h5, 8'd3, 3'd2, 2'b10, 1'b1);
        wait_idle();
        issue(32'h40, 4'h6, 8'd2, 3'd2, 2'b00, 1'b1);
        wait_idle();

        issue(32'h300, 4'h1, 8'd1, 3'd2, 2'b01, 1'b1);
        issue(32'h400, 4'h2, 8'd2, 3'd1, 2'b01, 1'b1);
        wait_idle();

        issue(32'h500, 4'hA, 8'd1, 3'd2, 2'b11, 1'b1);
        wait_idle();

        // Backpressure: hold rready low for 3 cycles on beat 2.
        rr_mode = 2;
        rready = 1'b1;
        issue(32'h600, 4'h7, 8'd3, 3'd2, 2'b01, 1'b0);
        n = 0;
        while (!(rvalid && sb.size() == 3) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        rready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rready = 1'b1;
        wait_idle();

        // An AR handshake while busy must be ignored.
        rr_mode = 0;
        issue(32'h700, 4'h8, 8'd2, 3'd2, 2'b01, 1'b0);
        arvalid = 1'b1; arready = 1'b1;
        stored_araddr = 32'h999; stored_arlen = 8'd5; stored_arburst = 2'b01;
        repeat (2) begin @(posedge clk); #1; end
        arvalid = 1'b0; arready = 1'b0;
        wait_idle();

        // Reset during beat 2 aborts the burst; a fresh one follows.
        issue(32'h800, 4'h9, 8'd3, 3'd2, 2'b01, 1'b1);
        n = 0;
        while (sb.size() > 3 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        rst = 1'b0;
        #1;
        chk("abort_ctrl", {busy, mem_rd_en, rvalid, rlast, r_transfer_done, rid, rresp}, 0);
        chk("abort_rdata", rdata, 0);
        sb.delete();
        aq.delete();
        @(negedge clk);
        chk("abort_ctrl_next", {busy, mem_rd_en, rvalid, rlast, r_transfer_done, rid, rresp}, 0);
        chk("abort_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        issue(32'h900, 4'hB, 8'd2, 3'd2, 2'b01, 1'b1);
        wait_idle();

        // Randomized bursts under random backpressure.
        rr_mode = 1;
        for (int i = 0; i < 40; i++) begin
            burst = 2'($urandom_range(0, 3));
            size  = 3'($urandom_range(0, 2));
            if (burst == 2'b10) len = 8'((2 << $urandom_range(0, 3)) - 1);
            else len = 8'($urandom_range(0, 15));
            issue($urandom & ~((32'd1 << size) - 32'd1), IW'($urandom), len, size, burst, 1'b0);
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi4_slave_read_data_channel.md
# axi4_slave_read_data_channel

AXI4 slave read-data responder, the read-side counterpart of the slave write-data channel. It accepts a burst descriptor latched by the read-address channel and generates FIXED/INCR/WRAP memory read addresses. It drives a synchronous-read memory port and returns RDATA/RID/RRESP/RLAST beats to the master under RREADY backpressure. It sits between the AR channel block and the shared slave memory in the AXI4 slave top.

## Interface
- DATA_WIDTH, 32, RDATA and memory data width in bits (power of 2, ≥8)
- ADDR_WIDTH, 32, address width
- ID_WIDTH, 4, ARID/RID width

Reset is rst, asynchronous, active-low; clock is clk.

- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous active-low reset
- arvalid  in  1  AR handshake observe
- arready  in  1  AR handshake observe (driven by AR channel block)
- stored_araddr  in  ADDR_WIDTH  burst start address, valid in AR handshake cycle
- stored_arid  in  ID_WIDTH  burst ID
- stored_arlen  in  8  beats minus one
- stored_arsize  in  3  log2 bytes per beat
- stored_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- busy  out  1  high whenever state ≠ R_IDLE; AR block must hold arready low while set
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_WIDTH  memory read address
- mem_rd_data  in  DATA_WIDTH  read data, valid cycle after mem_rd_en, held until next mem_rd_en
- rvalid  out  1  R channel valid
- rready  in  1  R channel ready from master
- rdata  out  DATA_WIDTH  mem_rd_data when rvalid, else 0
- rid  out  ID_WIDTH  latched ARID
- rresp  out  2  00 OKAY, 10 SLVERR
- rlast  out  1  rvalid && beats_remaining==1
- r_transfer_done  out  1  one-cycle pulse on final beat handshake

## Operation
- States: R_IDLE, R_FETCH, R_DATA.
- R_IDLE: on arvalid&&arready, latch ID, len+1 into beats_remaining (9 bits), size, burst, address; go R_FETCH. The handshake is ignored in other states.
- R_FETCH: mem_rd_en=1, mem_addr=current_addr; go R_DATA.
- R_DATA: rvalid=1. rvalid&&rready is a handshake. On the last beat, pulse r_transfer_done and go R_IDLE. Otherwise decrement beats_remaining, advance the address and go R_FETCH.
- No handshake: stay in R_DATA. rdata, rid, rresp and rlast stay stable, and mem_rd_en=0.
- Address advance, with num_bytes = 1<<size:
  - FIXED: hold.
  - INCR: +num_bytes.
  - WRAP: container = num_bytes*(len+1) and wrap_base = addr aligned down to container, both computed at latch. When current_addr + num_bytes reaches wrap_base+container, load wrap_base; otherwise +num_bytes.
- Reserved burst 11: address treated as INCR; rresp=10 on every beat of that burst. All other bursts return rresp=00.
- mem_addr is current_addr in every state; only mem_rd_en qualifies it.

## Timing
- Reset values: state R_IDLE; busy, mem_rd_en, rvalid, rlast and r_transfer_done are 0; rdata, rid, rresp and mem_addr are 0.
- Reset mid-burst aborts immediately with no further beats.
- Latency: AR handshake at cycle T gives mem_rd_en at T+1 and rvalid with the first rdata at T+2.
- Throughput without the macro: one beat per 2 cycles when rready stays high.
- rvalid never drops before its handshake.
- Back-to-back bursts: the next AR handshake is accepted the cycle after r_transfer_done. busy is low in that cycle.

## Configuration
- AXI_RD_PIPELINE_EN defined:
  - In R_DATA, a non-last handshake asserts mem_rd_en combinationally in the same cycle, with mem_addr set to the next address.
  - The block stays in R_DATA with rvalid held high; the next beat's data appears the following cycle.
  - Throughput is one beat per cycle; R_FETCH is used only for the first beat.
- Undefined: behaviour as in Operation, 2 cycles per beat, and mem_rd_en is never a function of rready.

## Test plan
- INCR, addr 0x100, len 3, size 2, rready=1:
  - mem_addr sequence 0x100/0x104/0x108/0x10C.
  - First rvalid at T+2; rlast and r_transfer_done on beat 4; rresp=00; rid as latched.
  - Without AXI_RD_PIPELINE_EN, beats at T+2/4/6/8; with it, at T+2/3/4/5.
- WRAP, addr 0x108, len 3, size 2: addresses 0x108/0x10C/0x100/0x104.
- FIXED, addr 0x40, len 2: three reads at 0x40, rlast on beat 3.
- Backpressure: rready low for 3 cycles on beat 2 of an INCR len 3 burst.
  - rvalid, rdata, rid and rlast stay stable; no mem_rd_en pulses.
  - The burst completes normally afterwards.
- Reserved burst 11, ID 0xA, len 1: two beats with rresp=10 and rid=0xA.
- Reset pulled low during beat 2: all outputs 0 the next cycle. A fresh burst after reset starts at T+2.
